// File: rtl/cacheline_burst_adaptor.sv
// Splits a cache-line fill or writeback into a burst of word beats on the
// physical-memory port, gathering read beats into a line buffer.
module cacheline_burst_adaptor #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ca_read,
  input  logic              ca_write,
  input  logic [ADDR_W-1:0] ca_addr,
  input  logic [LINE_W-1:0] ca_wdata,
  output logic [LINE_W-1:0] ca_rdata,
  output logic              ca_resp,
  output logic              pm_read,
  output logic              pm_write,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [WORD_W-1:0] pm_wdata,
  input  logic [WORD_W-1:0] pm_rdata,
  input  logic              pm_resp
);

  localparam int unsigned BEATS  = LINE_W / WORD_W;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned WORD_B = WORD_W / 8;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  if ((LINE_W % WORD_W) != 0 || BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_param_check
    $error("cacheline_burst_adaptor: LINE_W/WORD_W must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] beat_addr;
  logic [WORD_W-1:0] wbuf [BEATS];
  logic [WORD_W-1:0] rbuf [BEATS];

  assign line_base = ca_addr & ~OFF_MASK;
  assign beat_addr = base + ADDR_W'(cnt) * ADDR_W'(WORD_B);

  for (genvar g = 0; g < BEATS; g++) begin : g_rdata
    assign ca_rdata[g*WORD_W +: WORD_W] = rbuf[g];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; write wins when both requests are raised together
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (ca_write)     state_nx = WRITE;
        else if (ca_read) state_nx = READ;
      end
      WRITE, READ: begin
        if (pm_resp && (&cnt)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state and beat counter
  always_comb begin
    ca_resp  = 1'b0;
    pm_read  = 1'b0;
    pm_write = 1'b0;
    pm_addr  = '0;
    pm_wdata = '0;
    case (state)
      WRITE: begin
        pm_write = 1'b1;
        pm_addr  = beat_addr;
        pm_wdata = wbuf[cnt];
      end
      READ: begin
        pm_read = 1'b1;
        pm_addr = beat_addr;
      end
      DONE:    ca_resp = 1'b1;
      default: ;
    endcase
  end

  // Request latching, beat counting and read-beat capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      base <= '0;
      for (int unsigned i = 0; i < BEATS; i++) begin
        wbuf[i] <= '0;
        rbuf[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (ca_write) begin
            base <= line_base;
            cnt  <= '0;
            for (int unsigned i = 0; i < BEATS; i++) begin
              wbuf[i] <= ca_wdata[i*WORD_W +: WORD_W];
            end
          end else if (ca_read) begin
            base <= line_base;
            cnt  <= '0;
          end
        end
        WRITE: begin
          if (pm_resp) cnt <= cnt + CNT_W'(1);
        end
        READ: begin
          if (pm_resp) begin
            rbuf[cnt] <= pm_rdata;
            cnt       <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Scoreboard bench: the driver predicts every beat and completion from a
// line-level model, an independent monitor checks what the DUT presents.
module tb_cacheline_burst_adaptor;

  typedef struct {
    bit           cmp;
    bit           wr;
    logic [31:0]  addr;
    logic [31:0]  data;
    logic [255:0] line;
    longint       req_cyc;
    longint       exp_cyc;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  logic ca_read, ca_write, ca_resp, pm_read, pm_write, pm_resp;
  logic [31:0]  ca_addr, pm_addr, pm_wdata, pm_rdata;
  logic [255:0] ca_wdata, ca_rdata;

  logic u1_ca_read, u1_ca_write, u1_ca_resp, u1_pm_read, u1_pm_write, u1_pm_resp;
  logic [31:0]  u1_ca_addr, u1_pm_addr;
  logic [127:0] u1_ca_wdata, u1_ca_rdata;
  logic [63:0]  u1_pm_wdata, u1_pm_rdata;

  item_t        q[$];
  logic [255:0] model_line = '0;
  longint       cyc = 0;
  longint       req_cyc = 0;
  int           resp_mode = 0;
  bit           rd_dir = 1'b0;
  logic [31:0]  seed = '0;
  int           total = 0;
  int           bad = 0;

  cacheline_burst_adaptor u_dut (
    .clk(clk), .rst(rst), .ca_read(ca_read), .ca_write(ca_write),
    .ca_addr(ca_addr), .ca_wdata(ca_wdata), .ca_rdata(ca_rdata), .ca_resp(ca_resp),
    .pm_read(pm_read), .pm_write(pm_write), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .pm_rdata(pm_rdata), .pm_resp(pm_resp)
  );

  cacheline_burst_adaptor #(.LINE_W(128), .WORD_W(64), .ADDR_W(32)) u_dut2 (
    .clk(clk), .rst(rst), .ca_read(u1_ca_read), .ca_write(u1_ca_write),
    .ca_addr(u1_ca_addr), .ca_wdata(u1_ca_wdata), .ca_rdata(u1_ca_rdata), .ca_resp(u1_ca_resp),
    .pm_read(u1_pm_read), .pm_write(u1_pm_write), .pm_addr(u1_pm_addr), .pm_wdata(u1_pm_wdata),
    .pm_rdata(u1_pm_rdata), .pm_resp(u1_pm_resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents as a pure function of the beat address
  function automatic logic [31:0] mem_word(input logic [31:0] a, input bit dir, input logic [31:0] s);
    if (dir) return 32'hA000_0000 + ((a >> 2) & 32'h7);
    return (a * 32'h9E37_79B9) ^ s;
  endfunction

  always_comb pm_rdata = mem_word(pm_addr, rd_dir, seed);
  always_comb u1_pm_rdata = {~u1_pm_addr, u1_pm_addr};

  task automatic chk(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Memory handshake: always ready, ready on odd cycles of the burst, or random
  initial begin
    pm_resp = 1'b0;
    u1_pm_resp = 1'b1;
    forever begin
      @(negedge clk);
      case (resp_mode)
        0:       pm_resp = 1'b1;
        1:       pm_resp = ((cyc - req_cyc) % 2) == 1;
        default: pm_resp = $urandom_range(0, 3) != 0;
      endcase
    end
  end

  // Monitor: compares every cycle against the head of the expectation queue
  initial begin
    item_t it;
    bit eb, ec;
    @(posedge clk);
    forever begin
      @(negedge clk);
      #2;
      chk(!(pm_read && pm_write), "rw_exclusive", 256'({pm_read, pm_write}), 256'(0));
      if (pm_read || pm_write) begin
        eb = (q.size() != 0) && !q[0].cmp;
        chk(eb, "beat_expected", 256'(pm_addr), 256'(q.size()));
        if (eb) begin
          it = q[0];
          chk(pm_write == it.wr && pm_read == !it.wr, "beat_dir",
              256'({pm_read, pm_write}), 256'({!it.wr, it.wr}));
          chk(pm_addr == it.addr, "beat_addr", 256'(pm_addr), 256'(it.addr));
          if (it.wr) chk(pm_wdata == it.data, "beat_wdata", 256'(pm_wdata), 256'(it.data));
          if (pm_resp) void'(q.pop_front());
        end
      end else begin
        chk(pm_addr == 32'h0, "idle_addr", 256'(pm_addr), 256'(0));
        chk(pm_wdata == 32'h0, "idle_wdata", 256'(pm_wdata), 256'(0));
      end
      if (ca_resp) begin
        ec = (q.size() != 0) && q[0].cmp;
        chk(ec, "resp_expected", 256'(ca_resp), 256'(q.size()));
        if (ec) begin
          it = q.pop_front();
          if (it.exp_cyc >= 0)
            chk(cyc == it.exp_cyc, "resp_cycle", 256'(cyc - it.req_cyc), 256'(it.exp_cyc - it.req_cyc));
          if (it.wr) begin
            chk(ca_rdata == model_line, "wb_rdata_kept", ca_rdata, model_line);
          end else begin
            chk(ca_rdata == it.line, "fill_rdata", ca_rdata, it.line);
            model_line = it.line;
          end
        end
      end else if (!pm_read) begin
        chk(ca_rdata == model_line, "rdata_hold", ca_rdata, model_line);
      end
      if (rst) begin
        q.delete();
        model_line = '0;
      end
    end
  end

  // One cache transaction; abort_at>0 pulses rst in that cycle of the burst
  task automatic do_txn(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [255:0] wdata, input int mode, input bit dir, input int abort_at);
    item_t it;
    logic [31:0]  base;
    logic [31:0]  s;
    logic [255:0] line;
    bit done;
    int n;
    @(negedge clk);
    s = $urandom;
    seed = s;
    rd_dir = dir;
    resp_mode = mode;
    req_cyc = cyc;
    ca_write = wr;
    ca_read = rd;
    ca_addr = addr;
    ca_wdata = wdata;
    base = addr & 32'hFFFF_FFE0;
    for (int i = 0; i < 8; i++) begin
      it.cmp = 1'b0;
      it.wr = wr;
      it.addr = base + 32'(4 * i);
      it.data = wdata[i*32 +: 32];
      it.line = '0;
      it.req_cyc = cyc;
      it.exp_cyc = -1;
      line[i*32 +: 32] = mem_word(it.addr, dir, s);
      q.push_back(it);
    end
    it.cmp = 1'b1;
    it.addr = base;
    it.line = line;
    it.exp_cyc = (mode == 0) ? cyc + 9 : (mode == 1) ? cyc + 16 : -1;
    q.push_back(it);
    done = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (abort_at != 0 && n == abort_at) begin
        ca_read = 1'b0;
        ca_write = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        done = 1'b1;
      end else if (ca_resp) begin
        ca_read = 1'b0;
        ca_write = 1'b0;
        done = 1'b1;
      end else begin
        ca_read = 1'($urandom_range(0, 1));
        ca_write = 1'($urandom_range(0, 1));
        ca_addr = $urandom;
        ca_wdata = rnd_line();
      end
    end
    chk(done, "txn_done", 256'(n), 256'(200));
    if (!done) begin
      ca_read = 1'b0;
      ca_write = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  initial begin
    logic [255:0] inc;
    int k;
    rst = 1'b1;
    ca_read = 1'b0;
    ca_write = 1'b0;
    ca_addr = '0;
    ca_wdata = '0;
    u1_ca_read = 1'b0;
    u1_ca_write = 1'b0;
    u1_ca_addr = '0;
    u1_ca_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) inc[i*32 +: 32] = 32'(i);
    do_txn(1'b0, 1'b1, 32'h0000_1234, '0, 0, 1'b1, 0);
    do_txn(1'b1, 1'b0, 32'h0000_0040, inc, 0, 1'b0, 0);
    do_txn(1'b1, 1'b1, $urandom, rnd_line(), 0, 1'b0, 0);
    do_txn(1'b0, 1'b1, $urandom, '0, 0, 1'b0, 0);
    do_txn(1'b0, 1'b1, 32'h8000_1010, '0, 1, 1'b0, 0);
    do_txn(1'b0, 1'b1, 32'h0000_2008, '0, 0, 1'b0, 5);
    do_txn(1'b0, 1'b1, 32'h0000_2008, '0, 0, 1'b0, 0);
    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, 3);
      do_txn(k >= 2, k != 2, $urandom, rnd_line(), $urandom_range(0, 2), 1'b0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Two-beat variant: 16-byte line of 64-bit words
    @(negedge clk);
    u1_ca_read = 1'b1;
    u1_ca_addr = 32'h0000_5678;
    @(negedge clk);
    u1_ca_read = 1'b0;
    chk(u1_pm_read && !u1_pm_write && u1_pm_addr == 32'h5670, "w2_beat0",
        256'({u1_pm_read, u1_pm_addr}), 256'({1'b1, 32'h5670}));
    chk(!u1_ca_resp, "w2_no_early_resp", 256'(u1_ca_resp), 256'(0));
    @(negedge clk);
    chk(u1_pm_read && u1_pm_addr == 32'h5678, "w2_beat1",
        256'({u1_pm_read, u1_pm_addr}), 256'({1'b1, 32'h5678}));
    @(negedge clk);
    chk(u1_ca_resp && !u1_pm_read, "w2_resp", 256'({u1_ca_resp, u1_pm_read}), 256'(2'b10));
    chk(u1_ca_rdata == {~32'h5678, 32'h5678, ~32'h5670, 32'h5670}, "w2_rdata",
        256'(u1_ca_rdata), 256'({~32'h5678, 32'h5678, ~32'h5670, 32'h5670}));
    @(negedge clk);
    chk(!u1_ca_resp, "w2_resp_one_cycle", 256'(u1_ca_resp), 256'(0));

    repeat (3) @(negedge clk);
    chk(q.size() == 0, "queue_drained", 256'(q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
